// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray-code helpers and parameter legality checks for the level-reporting async FIFO
package fifo_pkg;

   // Binary to reflected Gray code; callers zero-extend and truncate to their pointer width
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary over the low w bits (upper bits are expected to be zero)
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < w; i++) b = b ^ (g >> i);
      return b;
   endfunction

   // True when the FIFO parameter set is inside its supported range
   function automatic bit params_ok(input int addr, input int stages, input int afull, input int aempty);
      return addr >= 2 && addr <= 12 && stages >= 2 &&
             afull >= 1 && afull <= (1 << addr) &&
             aempty >= 0 && aempty <= (1 << addr) - 1;
   endfunction

endpackage

// File: rtl/sync_bus.sv
// sync_bus: multi-flop bus synchroniser with asynchronous active-low reset
module sync_bus #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sr [STAGES];

   // shift the Gray pointer through STAGES flops in the destination domain
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < STAGES; i++) sr[i] <= '0;
      else begin
         sr[0] <= d;
         for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/async_fifo_lvl.sv
// async_fifo_lvl: dual-clock Gray-pointer FIFO with fill levels, almost flags and sticky error flags
module async_fifo_lvl
   import fifo_pkg::*;
#(
   parameter int DATASIZE      = 8,
   parameter int ADDRSIZE      = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic [DATASIZE-1:0] wdata,
   input  logic                winc,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                wovf,
   input  logic                rinc,
   output logic [DATASIZE-1:0] rdata,
   output logic                rempty,
   output logic                ralmost_empty,
   output logic [ADDRSIZE:0]   rlevel,
   output logic                rudf
);

   localparam int DEPTH = 1 << ADDRSIZE;
   localparam int PW    = ADDRSIZE + 1;

   if (!params_ok(ADDRSIZE, SYNC_STAGES, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
      $error("async_fifo_lvl: parameter set out of legal range");
   end

   logic [DATASIZE-1:0] mem [DEPTH];

   logic [PW-1:0] wbin, wgray, wbin_next, wgray_next, rgray_w, rbin_w, wlevel_next;
   logic [PW-1:0] rbin, rgray, rbin_next, rgray_next, wgray_r, wbin_r, rlevel_next;
   logic          push, pop, wfull_next, rempty_next;

   sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
      .clk   (wclk),
      .rst_n (wrst_n),
      .d     (rgray),
      .q     (rgray_w)
   );

   sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
      .clk   (rclk),
      .rst_n (rrst_n),
      .d     (wgray),
      .q     (wgray_r)
   );

   // write-side next pointer and flags; full compares against the synced read pointer with its top two bits inverted
   always_comb begin
      push        = winc & ~wfull;
      wbin_next   = wbin + PW'(push);
      wgray_next  = PW'(bin2gray(32'(wbin_next)));
      rbin_w      = PW'(gray2bin(32'(rgray_w), PW));
      wlevel_next = wbin_next - rbin_w;
      wfull_next  = wgray_next == {~rgray_w[PW-1 -: 2], rgray_w[PW-3:0]};
   end

   // write-side state; overflow stays set until the write reset
   always_ff @(posedge wclk or negedge wrst_n)
      if (!wrst_n) begin
         wbin         <= '0;
         wgray        <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         wovf         <= 1'b0;
      end else begin
         wbin         <= wbin_next;
         wgray        <= wgray_next;
         wfull        <= wfull_next;
         walmost_full <= int'(wlevel_next) >= AFULL_THRESH;
         wlevel       <= wlevel_next;
         wovf         <= wovf | (winc & wfull);
      end

   // storage array, written only on accepted pushes and never reset
   always_ff @(posedge wclk)
      if (push) mem[wbin[ADDRSIZE-1:0]] <= wdata;

   assign rdata = mem[rbin[ADDRSIZE-1:0]];

   // read-side next pointer and flags against the synced write pointer
   always_comb begin
      pop         = rinc & ~rempty;
      rbin_next   = rbin + PW'(pop);
      rgray_next  = PW'(bin2gray(32'(rbin_next)));
      wbin_r      = PW'(gray2bin(32'(wgray_r), PW));
      rlevel_next = wbin_r - rbin_next;
      rempty_next = rgray_next == wgray_r;
   end

   // read-side state; underflow stays set until the read reset
   always_ff @(posedge rclk or negedge rrst_n)
      if (!rrst_n) begin
         rbin          <= '0;
         rgray         <= '0;
         rempty        <= 1'b1;
         ralmost_empty <= 1'b1;
         rlevel        <= '0;
         rudf          <= 1'b0;
      end else begin
         rbin          <= rbin_next;
         rgray         <= rgray_next;
         rempty        <= rempty_next;
         ralmost_empty <= int'(rlevel_next) <= AEMPTY_THRESH;
         rlevel        <= rlevel_next;
         rudf          <= rudf | (rinc & rempty);
      end

endmodule

// File: tb/tb_async_fifo_lvl.sv
// tb_async_fifo_lvl: directed and randomized checks of async_fifo_lvl against a queue model
module tb_async_fifo_lvl;

   logic       wclk = 1'b0, rclk = 1'b0, wrst_n = 1'b0, rrst_n = 1'b0;
   logic [7:0] wdata = '0, rdata;
   logic       winc = 1'b0, rinc = 1'b0;
   logic       wfull, walmost_full, wovf, rempty, ralmost_empty, rudf;
   logic [4:0] wlevel, rlevel;

   int         errors = 0, checks = 0, npop = 0, nw = 0;
   bit         lvl_on = 1'b0;
   logic [7:0] q [$];

   async_fifo_lvl dut (
      .wclk          (wclk),
      .wrst_n        (wrst_n),
      .rclk          (rclk),
      .rrst_n        (rrst_n),
      .wdata         (wdata),
      .winc          (winc),
      .wfull         (wfull),
      .walmost_full  (walmost_full),
      .wlevel        (wlevel),
      .wovf          (wovf),
      .rinc          (rinc),
      .rdata         (rdata),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .rlevel        (rlevel),
      .rudf          (rudf)
   );

   always #50  wclk = ~wclk;
   always #135 rclk = ~rclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // model: record every accepted write in order
   always @(posedge wclk)
      if (wrst_n && winc && !wfull) q.push_back(wdata);

   // model: every accepted pop must present the oldest unread word
   always @(posedge rclk)
      if (rrst_n && rinc && !rempty) begin
         chk("rd_model_nonempty", 32'(q.size() > 0), 32'd1);
         if (q.size() > 0) chk("rd_data", 32'(rdata), 32'(q.pop_front()));
         npop++;
      end

   // levels must stay within depth and never under-report (write) or over-report (read) true occupancy
   always @(negedge wclk)
      if (lvl_on) begin
         chk("wlevel_max", 32'(wlevel <= 5'd16), 32'd1);
         chk("wlevel_safe", 32'(int'(wlevel) >= q.size()), 32'd1);
      end

   always @(negedge rclk)
      if (lvl_on) begin
         chk("rlevel_max", 32'(rlevel <= 5'd16), 32'd1);
         chk("rlevel_safe", 32'(int'(rlevel) <= q.size()), 32'd1);
      end

   task automatic wr(input logic [7:0] d);
      @(negedge wclk);
      winc  = 1'b1;
      wdata = d;
      @(negedge wclk);
      winc  = 1'b0;
   endtask

   task automatic rd();
      @(negedge rclk);
      rinc = 1'b1;
      @(negedge rclk);
      rinc = 1'b0;
   endtask

   task automatic do_reset();
      winc   = 1'b0;
      rinc   = 1'b0;
      wrst_n = 1'b0;
      rrst_n = 1'b0;
      repeat (4) @(negedge rclk);
      q.delete();
      wrst_n = 1'b1;
      rrst_n = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      @(negedge wclk);
      chk({tag, "_wfull"}, 32'(wfull), 32'd0);
      chk({tag, "_walmost_full"}, 32'(walmost_full), 32'd0);
      chk({tag, "_wlevel"}, 32'(wlevel), 32'd0);
      chk({tag, "_wovf"}, 32'(wovf), 32'd0);
      @(negedge rclk);
      chk({tag, "_rempty"}, 32'(rempty), 32'd1);
      chk({tag, "_ralmost_empty"}, 32'(ralmost_empty), 32'd1);
      chk({tag, "_rlevel"}, 32'(rlevel), 32'd0);
      chk({tag, "_rudf"}, 32'(rudf), 32'd0);
   endtask

   initial begin
      // 1. reset
      do_reset();
      chk_reset_vals("rst");

      // 4. random traffic with incrementing data across the clock ratio
      lvl_on = 1'b1;
      fork
         begin
            for (int k = 0; k < 20000 && nw < 1000; k++) begin
               @(negedge wclk);
               winc  = ($urandom_range(0, 1) == 1) && !wfull;
               wdata = 8'(nw);
               if (winc) nw++;
            end
            @(negedge wclk);
            winc = 1'b0;
         end
         begin
            for (int k = 0; k < 20000 && npop < 1000; k++) begin
               @(negedge rclk);
               rinc = ($urandom_range(0, 2) != 0) && !rempty;
            end
            rinc = 1'b0;
         end
      join
      lvl_on = 1'b0;
      chk("rand_writes", 32'(nw), 32'd1000);
      chk("rand_pops", 32'(npop), 32'd1000);
      chk("rand_wovf", 32'(wovf), 32'd0);
      chk("rand_rudf", 32'(rudf), 32'd0);
      for (int k = 0; k < 50 && wlevel != 0; k++) @(negedge wclk);
      chk("rand_wlevel_settle", 32'(wlevel), 32'd0);

      // 2. fill, overflow, drain
      for (int i = 0; i < 16; i++) begin
         chk("fill_not_full", 32'(wfull), 32'd0);
         wr(8'(i));
      end
      chk("fill_wfull", 32'(wfull), 32'd1);
      chk("fill_wlevel", 32'(wlevel), 32'd16);
      chk("fill_wovf_clear", 32'(wovf), 32'd0);
      wr(8'hAA);
      chk("ovf_wovf", 32'(wovf), 32'd1);
      chk("ovf_wlevel", 32'(wlevel), 32'd16);
      for (int k = 0; k < 50 && rlevel != 16; k++) @(negedge rclk);
      chk("drain_rlevel16", 32'(rlevel), 32'd16);
      for (int i = 0; i < 16; i++) begin
         chk("drain_data", 32'(rdata), 32'(i));
         rd();
      end
      chk("drain_rempty", 32'(rempty), 32'd1);
      chk("drain_rlevel0", 32'(rlevel), 32'd0);
      for (int k = 0; k < 50 && wlevel != 0; k++) @(negedge wclk);
      chk("drain_wlevel0", 32'(wlevel), 32'd0);

      // 3. thresholds
      for (int k = 1; k <= 12; k++) begin
         wr(8'($urandom));
         chk("thr_wlevel", 32'(wlevel), 32'(k));
         chk("thr_walmost_full", 32'(walmost_full), 32'(k >= 12));
      end
      for (int k = 0; k < 50 && rlevel != 12; k++) @(negedge rclk);
      chk("thr_rlevel12", 32'(rlevel), 32'd12);
      for (int j = 1; j <= 8; j++) begin
         rd();
         chk("thr_rlevel", 32'(rlevel), 32'(12 - j));
         chk("thr_ralmost_empty", 32'(ralmost_empty), 32'(12 - j <= 4));
      end
      repeat (4) rd();
      chk("thr_rempty", 32'(rempty), 32'd1);
      for (int k = 0; k < 50 && wlevel != 0; k++) @(negedge wclk);
      chk("thr_wlevel0", 32'(wlevel), 32'd0);

      // 5. underflow, then fall-through latency of the next word
      rd();
      chk("udf_rudf", 32'(rudf), 32'd1);
      chk("udf_rempty", 32'(rempty), 32'd1);
      chk("udf_rlevel", 32'(rlevel), 32'd0);
      @(negedge wclk);
      winc  = 1'b1;
      wdata = 8'h5C;
      @(posedge wclk);
      #1 winc = 1'b0;
      for (int k = 0; k < 4 && rempty; k++) begin
         @(posedge rclk);
         #1;
      end
      chk("lat_rempty", 32'(rempty), 32'd0);
      chk("udf_next_data", 32'(rdata), 32'h5C);
      rd();
      chk("udf_sticky", 32'(rudf), 32'd1);
      chk("ovf_sticky", 32'(wovf), 32'd1);

      // 6. reset in the middle of traffic
      for (int i = 0; i < 5; i++) wr(8'(8'h10 + i));
      repeat (2) @(negedge rclk);
      do_reset();
      chk_reset_vals("mid_rst");
      wr(8'h33);
      for (int k = 0; k < 20 && rempty; k++) @(negedge rclk);
      chk("mid_rst_rempty", 32'(rempty), 32'd0);
      chk("mid_rst_data", 32'(rdata), 32'h33);
      rd();
      chk("mid_rst_drained", 32'(rempty), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/async_fifo_lvl.md
Name: async_fifo_lvl

Overview:
Parametrised dual-clock FIFO using Gray-coded pointers, the next generation of the team's basic async FIFO. It adds configurable synchroniser depth, fill-level outputs in both clock domains, programmable almost-full and almost-empty flags, and sticky overflow and underflow error flags. It sits between independent clock domains, for example a capture front-end on wclk and a processing core on rclk.

Parameters:
DATASIZE, 8, data word width in bits.
ADDRSIZE, 4, log2 of depth; DEPTH = 1<<ADDRSIZE; legal range 2..12.
SYNC_STAGES, 2, flops per pointer synchroniser; minimum 2.
AFULL_THRESH, 12, walmost_full asserts when wlevel >= this value; legal range 1..DEPTH.
AEMPTY_THRESH, 4, ralmost_empty asserts when rlevel <= this value; legal range 0..DEPTH-1.

Ports:
wclk  in  1  write clock.
wrst_n  in  1  write-domain reset, asynchronous, active-low.
rclk  in  1  read clock.
rrst_n  in  1  read-domain reset, asynchronous, active-low.
wdata  in  DATASIZE  write data.
winc  in  1  write request.
wfull  out  1  FIFO full (wclk domain).
walmost_full  out  1  level >= AFULL_THRESH (wclk domain).
wlevel  out  ADDRSIZE+1  write-side fill level, 0..DEPTH.
wovf  out  1  sticky overflow flag.
rinc  in  1  read request / pop.
rdata  out  DATASIZE  head-of-FIFO data, first-word fall-through.
rempty  out  1  FIFO empty (rclk domain).
ralmost_empty  out  1  level <= AEMPTY_THRESH (rclk domain).
rlevel  out  ADDRSIZE+1  read-side fill level, 0..DEPTH.
rudf  out  1  sticky underflow flag.

Behaviour:
- Pointers are ADDRSIZE+1 bits, held as binary plus a registered Gray copy. Only the Gray copy crosses domains, through SYNC_STAGES flops clocked in the destination domain and reset by the destination reset.
- Write: accepted at a wclk edge iff winc=1 and wfull=0. The memory is written at waddr and wbin increments. If winc=1 and wfull=1, nothing is written, pointers hold, and wovf sets at that edge.
- Read: rdata = mem[raddr] combinationally and is valid whenever rempty=0. A pop is accepted iff rinc=1 and rempty=0; rbin then increments. If rinc=1 and rempty=1, the pointer holds and rudf sets at that edge.
- wovf and rudf are cleared only by their own domain's reset.
- Flag computation: all flags and levels are registered from next-pointer values, so they reflect an accepted op one edge after it is accepted.
  - rempty = (rgraynext == synced wptr).
  - wfull = (wgraynext == synced rptr with its top 2 bits inverted).
  - wlevel = wbinnext - gray2bin(synced rptr), modulo 2^(ADDRSIZE+1).
  - rlevel = gray2bin(synced wptr) - rbinnext, same modulo.
  - walmost_full = (wlevel_next >= AFULL_THRESH); ralmost_empty = (rlevel_next <= AEMPTY_THRESH).
- Pessimism: flags are conservative. wfull and walmost_full deassert, and rempty and ralmost_empty deassert, only after SYNC_STAGES+1 edges of the observing clock. Levels may lag the true occupancy by the same amount, never in the unsafe direction.
- Latency: a write into an empty FIFO makes rempty fall no later than SYNC_STAGES+2 rclk edges after the write edge.
- Wrap-around: pointers wrap at 2^(ADDRSIZE+1) with no special case. The MSB distinguishes full from empty.
- Simultaneous winc and rinc at full or empty: each side judges only its own registered flag. A write at full is dropped even if a read occurs in the same wall-clock instant.
- Reset values:
  - Write side: wfull=0, walmost_full=0, wlevel=0, wovf=0, write pointers 0.
  - Read side: rempty=1, ralmost_empty=1, rlevel=0, rudf=0, read pointers 0.
  - Memory is not reset.
- Reset mid-operation: wrst_n and rrst_n must be asserted together, overlapping for at least SYNC_STAGES edges of each clock; contents are then discarded. Asserting only one side is unsupported and is not verified.

Decomposition:
- Package fifo_pkg holds the bin2gray and gray2bin functions, parameterised by width, and the legal-range checks for the parameters.
- Sub-module sync_bus (WIDTH, STAGES): multi-flop synchroniser with asynchronous active-low reset. It is instantiated twice, once per pointer direction.
- Memory is inferred inline in async_fifo_lvl.

Test Plan:
1. Reset: assert both resets, then release -> wfull=0, walmost_full=0, wlevel=0, wovf=0, rempty=1, ralmost_empty=1, rlevel=0, rudf=0.
2. Fill and drain (DEPTH=16):
   - Write 0x00..0x0F -> wfull=1 the edge after the 16th write; wlevel=16.
   - A 17th write of 0xAA -> dropped, wovf=1.
   - Drain -> rdata reads 0x00..0x0F in order, rempty=1 after the 16th pop, 0xAA never appears.
3. Thresholds: write 12 words -> walmost_full=1 after the 12th accepted write. Then, after rlevel reaches 12, pop 8 -> rlevel=4 and ralmost_empty=1; at rlevel=5, ralmost_empty=0.
4. Wrap with clock ratio: wclk 100 MHz, rclk 37 MHz, random winc/rinc, 1000 words with an incrementing pattern -> in-order match, wovf=0, rudf=0, wlevel and rlevel never exceed 16.
5. Underflow: rinc=1 while empty -> rudf=1; read pointer unchanged; the next written word 0x5C is the next rdata.
6. Mid-operation reset: write 5 words, assert both resets -> all outputs return to reset values. Then write 0x33 -> rdata=0x33 is the first value read.
